alu_seq_param: RTL and testbench

- Parametrised, handshaked successor to the team's fixed 8-bit ALU.
- Takes operands A/B of WIDTH bits with a 3-bit opcode over a valid/ready input handshake.
- Computes ADD/SUB/AND/OR/XOR in one cycle, and unsigned MUL with an iterative shift-add engine over WIDTH cycles.
- Holds a registered 2*WIDTH-bit result with flags until the consumer accepts it. It sits between the instruction decoder and the result writeback stage.

---
 rtl/alu_seq_param.sv | 149 ++++++++++++++
 tb/tb_alu_seq_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked ALU: single-cycle add/sub/logic, iterative shift-add unsigned multiply
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Y,
  output logic               Cout,
  output logic               overflow,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_y;
  logic               r_cout;
  logic               r_ovf;
  logic               r_err;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_last_iter;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_o;
  logic               w_e;

  assign in_ready    = (r_state == S_IDLE) && !reset;
  assign out_valid   = (r_state == S_DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (opcode == 3'b101);
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
  assign w_acc_next  = r_mplier[0] ? r_acc + r_mcand : r_acc;

  // Bit WIDTH of the widened difference is the unsigned borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  assign Y        = r_y;
  assign Cout     = r_cout;
  assign overflow = r_ovf;
  assign err      = r_err;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_e   = 1'b0;
    case (opcode)
      3'b000: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_o   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  w_res = a & b;
      3'b011:  w_res = a ^ b;
      3'b100:  w_res = a | b;
      3'b101:  w_res = '0;
      default: w_e   = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:   if (w_last_iter) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers only change on a single-cycle accept or the final multiply step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_y      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_y    <= {{WIDTH{1'b0}}, w_res};
              r_cout <= w_c;
              r_ovf  <= w_o;
              r_err  <= w_e;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last_iter) begin
            r_y    <= w_acc_next;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - directed and randomized self-check of alu_seq_param against a behavioural model
module tb_alu_seq_param;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2:0]     opcode = 3'd0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] Y;
  logic           Cout;
  logic           overflow;
  logic           err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Cout      (Cout),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [2*W-1:0] r, output logic c, output logic ov,
                               output logic e);
    longint ux, uy, sx, sy, lim, s;
    lim = longint'(1) << W;
    ux  = longint'(x);
    uy  = longint'(y);
    sx  = (ux >= lim / 2) ? ux - lim : ux;
    sy  = (uy >= lim / 2) ? uy - lim : uy;
    r = '0; c = 1'b0; ov = 1'b0; e = 1'b0;
    case (o)
      3'd0: begin
        s  = ux + uy;
        r  = (2*W)'(s % lim);
        c  = (s >= lim);
        ov = (sx + sy > lim / 2 - 1) || (sx + sy < -(lim / 2));
      end
      3'd1: begin
        r  = (2*W)'((ux - uy + lim) % lim);
        c  = (ux < uy);
        ov = (sx - sy > lim / 2 - 1) || (sx - sy < -(lim / 2));
      end
      3'd2:    r = (2*W)'(ux & uy);
      3'd3:    r = (2*W)'(ux ^ uy);
      3'd4:    r = (2*W)'(ux | uy);
      3'd5:    r = (2*W)'(ux * uy);
      default: e = 1'b1;
    endcase
  endfunction

  // Model: one operation in flight; visible result appears after a fixed number of edges.
  bit             m_busy;
  int             m_cnt;
  logic [2*W-1:0] m_y, p_y;
  logic           m_c, m_o, m_e, p_c, p_o, p_e;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_cnt = 0;
      m_y = '0; m_c = 1'b0; m_o = 1'b0; m_e = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        calc(opcode, a, b, p_y, p_c, p_o, p_e);
        m_busy = 1'b1;
        m_cnt  = (opcode == 3'd5) ? W : 0;
        if (m_cnt == 0) begin m_y = p_y; m_c = p_c; m_o = p_o; m_e = p_e; end
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_y = p_y; m_c = p_c; m_o = p_o; m_e = p_e; end
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready", in_ready, !m_busy && !reset);
      check("out_valid", out_valid, m_busy && m_cnt == 0);
      check("Y", Y, m_y);
      check("Cout", Cout, m_c);
      check("overflow", overflow, m_o);
      check("err", err, m_e);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_lat, input logic [2*W-1:0] ey, input logic ec,
                        input logic eo, input logic ee);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    check("lit_ready_before_op", in_ready, 1);
    in_valid = 1'b1; opcode = o; a = x; b = y;
    @(negedge clock);
    in_valid = 1'b0; opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clock); n++; end
    check("lit_latency", n, exp_lat);
    check("lit_Y", Y, ey);
    check("lit_Cout", Cout, ec);
    check("lit_overflow", overflow, eo);
    check("lit_err", err, ee);
  endtask

  task automatic handoff(input int hold);
    repeat (hold) @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("lit_ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    check("lit_reset_ready", in_ready, 0);
    check("lit_reset_valid", out_valid, 0);
    check("lit_reset_Y", Y, 0);
    #2 reset = 1'b0;
    @(negedge clock);

    run_op(3'd0, 8'h7F, 8'h01, 1, 16'h0080, 1'b0, 1'b1, 1'b0); handoff(0);
    run_op(3'd0, 8'hFF, 8'h01, 1, 16'h0000, 1'b1, 1'b0, 1'b0); handoff(1);
    run_op(3'd1, 8'h00, 8'h01, 1, 16'h00FF, 1'b1, 1'b0, 1'b0); handoff(0);
    run_op(3'd1, 8'h80, 8'h01, 1, 16'h007F, 1'b0, 1'b1, 1'b0); handoff(2);
    run_op(3'd5, 8'hFF, 8'hFF, 9, 16'hFE01, 1'b0, 1'b0, 1'b0); handoff(0);
    run_op(3'd5, 8'h0A, 8'h00, 9, 16'h0000, 1'b0, 1'b0, 1'b0); handoff(0);

    run_op(3'd2, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; opcode = 3'd0; a = W'($urandom); b = W'($urandom);
      @(negedge clock);
      check("lit_bp_Y", Y, 16'h0030);
      check("lit_bp_valid", out_valid, 1);
      check("lit_bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handoff(0);
    check("lit_post_handoff_valid", out_valid, 0);
    check("lit_post_handoff_Y", Y, 16'h0030);

    in_valid = 1'b1; opcode = 3'd5; a = 8'hFF; b = 8'hFF;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("lit_rst_Y", Y, 0);
    check("lit_rst_valid", out_valid, 0);
    check("lit_rst_ready", in_ready, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("lit_rst_release_ready", in_ready, 1);
    @(negedge clock);
    run_op(3'd3, 8'hAA, 8'hFF, 1, 16'h0055, 1'b0, 1'b0, 1'b0); handoff(0);
    repeat (12) @(negedge clock);
    check("lit_no_stale_mul", out_valid, 0);

    run_op(3'd6, 8'h12, 8'h34, 1, 16'h0000, 1'b0, 1'b0, 1'b1); handoff(0);
    run_op(3'd4, 8'h12, 8'h34, 1, 16'h0036, 1'b0, 1'b0, 1'b0); handoff(0);

    for (int i = 0; i < 800; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      opcode    = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
